// File: rtl/regdet_pkg.sv
// Shared constants for the registered parity detector.
// Default word width and parity-mode selectors.
package regdet_pkg;

  localparam int DEF_N    = 4;
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/regdet_par_tree.sv
// Combinational XOR reduction built as a balanced binary tree.
// Depth is ceil(log2 N): each level halves the word.
module parity_tree
  import regdet_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] data,
  output logic         p
);

  if (N == 1) begin : g_leaf
    assign p = data[0];
  end else begin : g_node
    localparam int L = N / 2;

    logic p_lo;
    logic p_hi;

    parity_tree #(.N(L)) u_lo (
      .data (data[L-1:0]),
      .p    (p_lo)
    );

    parity_tree #(.N(N - L)) u_hi (
      .data (data[N-1:L]),
      .p    (p_hi)
    );

    assign p = p_lo ^ p_hi;
  end

endmodule

// File: rtl/regdet_par.sv
// Registered parity flag: one-cycle latency, output straight from a flop.
// ODD=0 flags an even count of ones, ODD=1 an odd count.
module regdet_par
  import regdet_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int ODD = PAR_EVEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic         out
);

  localparam logic INV = (ODD == PAR_ODD) ? 1'b0 : 1'b1;

  logic par;

  parity_tree #(.N(N)) u_tree (
    .data (in),
    .p    (par)
  );

  // Only the parity of the sampled word is observable, so the flop
  // captures the reduced bit rather than the whole word.
  always_ff @(posedge clk) begin
    if (!reset) out <= 1'b0;
    else        out <= par ^ INV;
  end

endmodule

// File: tb/tb_regdet_par.sv
// Directed and reference-model checks for regdet_par.
// Builds: N=4 even, N=4 odd, N=1 even, N=8 even.
module tb_regdet_par;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_e = 4'b0;
  logic [3:0] in_o = 4'b0;
  logic [0:0] in_1 = 1'b0;
  logic [7:0] in_8 = 8'b0;
  logic       out_e, out_o, out_1, out_8;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  regdet_par #(.N(4), .ODD(0)) u_even (
    .clk(clk), .reset(reset), .in(in_e), .out(out_e));
  regdet_par #(.N(4), .ODD(1)) u_odd (
    .clk(clk), .reset(reset), .in(in_o), .out(out_o));
  regdet_par #(.N(1), .ODD(0)) u_n1 (
    .clk(clk), .reset(reset), .in(in_1), .out(out_1));
  regdet_par #(.N(8), .ODD(0)) u_n8 (
    .clk(clk), .reset(reset), .in(in_8), .out(out_8));

  task automatic cyc(input logic r, input logic [3:0] e,
                     input logic [3:0] o, input logic a1,
                     input logic [7:0] a8);
    @(negedge clk);
    reset = r;
    in_e  = e;
    in_o  = o;
    in_1  = a1;
    in_8  = a8;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  function automatic logic ref_par8(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c[0];
  endfunction

  initial begin
    logic [15:0] odd_tbl;
    logic [7:0]  r8;
    odd_tbl = 16'b0110_1001_1001_0110;

    cyc(1'b0, 4'b1111, 4'b0111, 1'b0, 8'h00);
    chk("rst_even", out_e, 1'b0);
    chk("rst_odd",  out_o, 1'b0);
    chk("rst_n1",   out_1, 1'b0);
    chk("rst_n8",   out_8, 1'b0);

    cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00);
    chk("e0000", out_e, 1'b1);
    chk("n1_0",  out_1, 1'b1);
    chk("n8_00", out_8, 1'b1);
    cyc(1'b1, 4'b0011, 4'b0000, 1'b1, 8'hff);
    chk("e0011", out_e, 1'b1);
    chk("n1_1",  out_1, 1'b0);
    chk("n8_ff", out_8, 1'b1);
    cyc(1'b1, 4'b0001, 4'b0000, 1'b0, 8'h80);
    chk("e0001", out_e, 1'b0);
    chk("n8_80", out_8, 1'b0);
    cyc(1'b1, 4'b0111, 4'b0000, 1'b0, 8'h00);
    chk("e0111", out_e, 1'b0);
    cyc(1'b1, 4'b1111, 4'b0000, 1'b0, 8'h00);
    chk("e1111", out_e, 1'b1);

    cyc(1'b1, 4'b1010, 4'b0000, 1'b0, 8'h00);
    chk("b2b_1010", out_e, 1'b1);
    cyc(1'b1, 4'b1000, 4'b0000, 1'b0, 8'h00);
    chk("b2b_1000", out_e, 1'b0);
    cyc(1'b1, 4'b1001, 4'b0000, 1'b0, 8'h00);
    chk("b2b_1001", out_e, 1'b1);

    cyc(1'b0, 4'b0110, 4'b0001, 1'b0, 8'h01);
    chk("mid_rst_e", out_e, 1'b0);
    chk("mid_rst_o", out_o, 1'b0);
    chk("mid_rst_1", out_1, 1'b0);
    chk("mid_rst_8", out_8, 1'b0);
    cyc(1'b1, 4'b0110, 4'b0001, 1'b0, 8'h01);
    chk("resume_e", out_e, 1'b1);
    chk("resume_o", out_o, 1'b1);
    chk("resume_8", out_8, 1'b0);

    for (int v = 0; v < 16; v++) begin
      cyc(1'b1, 4'b0000, 4'(v), 1'b0, 8'h00);
      chk($sformatf("odd_%0d", v), out_o, odd_tbl[v]);
    end

    for (int k = 0; k < 40; k++) begin
      r8 = 8'($urandom_range(0, 255));
      cyc(1'b1, 4'b0000, 4'b0000, r8[0], r8);
      chk($sformatf("n8_rnd_%02h", r8), out_8, ~ref_par8(r8));
      chk($sformatf("n1_rnd_%0d", r8[0]), out_1, ~r8[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
